ifilter_lattice_free_p: RTL and testbench

Parametrised LPC inverse (analysis) filter. It computes one frame of prediction residue e[n] = x[n] - round(sum_{k=1..ORDER} a[k]*x[n-k]).
Samples are read from the frame sample RAM and coefficients from the coefficient RAM. Results are written to the residue RAM.
Compared with the fixed-order ifilter, it adds:
- configurable order, frame length and widths;
- a start/done handshake;
- rounding and saturation;
- optional cross-frame history, so that x[n-k] for n-k<0 comes from the previous frame.

---
 rtl/ifilter_lattice_free_p.sv | 207 ++++++++++++++++++++
 tb/tb_ifilter_lattice_free_p.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifilter_lattice_free_p.sv
// LPC analysis filter: one frame of prediction residue per start, with
// rounding, saturation and optional cross-frame tap history.
module ifilter_lattice_free_p #(
    parameter int ORDER       = 10,
    parameter int FRAME_LEN   = 256,
    parameter int XW          = 16,
    parameter int CW          = 32,
    parameter int CFRAC       = 24,
    parameter int USE_HISTORY = 1,
    localparam int ADDR_W     = $clog2(FRAME_LEN),
    localparam int KW         = (ORDER > 1) ? $clog2(ORDER) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     clear_history,
    output logic                     ready,
    output logic                     done,
    output logic                     sat,
    output logic [KW-1:0]            a_raddr,
    input  logic signed [CW-1:0]     a_rdata,
    output logic [ADDR_W-1:0]        x_raddr,
    input  logic signed [XW-1:0]     x_rdata,
    output logic [ADDR_W-1:0]        res_waddr,
    output logic                     res_wen,
    output logic signed [XW-1:0]     res_wdata
);

    localparam int KCW   = $clog2(ORDER + 1);
    localparam int ACC_W = XW + CW + $clog2(ORDER + 1);
    localparam int PW    = XW + CW;
    localparam int RW    = ACC_W + 2;
    localparam int IW    = ((ADDR_W > KCW) ? ADDR_W : KCW) + 1;

    localparam logic signed [ACC_W:0] HALF =
        (ACC_W + 1)'(1) << (CFRAC - 1);
    localparam logic signed [RW-1:0] RMAX =
        {{(RW - XW + 1){1'b0}}, {(XW - 1){1'b1}}};
    localparam logic signed [RW-1:0] RMIN =
        {{(RW - XW + 1){1'b1}}, {(XW - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0]       n;
    logic [KCW-1:0]          k;
    logic [KCW-1:0]          kd;
    logic                    kd_vld;
    logic signed [ACC_W-1:0] acc;
    logic signed [XW-1:0]    xn;
    logic signed [XW-1:0]    hist [ORDER];
    logic signed [XW-1:0]    shadow [ORDER];

    logic                    accept;
    logic                    last_tap;
    logic                    last_n;
    logic [IW-1:0]           nw;
    logic [IW-1:0]           kw;
    logic [IW-1:0]           hidx;
    logic signed [XW-1:0]    tap_x;
    logic signed [PW-1:0]    a_ext;
    logic signed [PW-1:0]    x_ext;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W:0]   rsum;
    logic signed [ACC_W:0]   pq;
    logic signed [RW-1:0]    xr;
    logic signed [RW-1:0]    pr;
    logic signed [RW-1:0]    r;
    logic                    clip;

    assign ready    = (state == S_IDLE) || (state == S_DONE);
    assign done     = (state == S_DONE);
    assign res_wen  = (state == S_WRITE);
    assign accept   = start && ready;
    assign last_tap = (k == KCW'(ORDER));
    assign last_n   = (n == ADDR_W'(FRAME_LEN - 1));

    assign x_raddr   = (state == S_ISSUE) ?
                       ADDR_W'(IW'(n) - IW'(k)) : '0;
    assign a_raddr   = (state == S_ISSUE && k != '0) ?
                       KW'(k - KCW'(1)) : '0;
    assign res_waddr = (state == S_WRITE) ? n : '0;

    // Tap index relative to n of the data returning this cycle
    assign nw   = IW'(n);
    assign kw   = IW'(kd);
    assign hidx = kw - nw - IW'(1);

    always_comb begin
        tap_x = '0;
        if (nw >= kw) begin
            tap_x = x_rdata;
        end else if (USE_HISTORY != 0) begin
            for (int j = 0; j < ORDER; j++) begin
                if (hidx == IW'(j)) begin
                    tap_x = hist[j];
                end
            end
        end
    end

    assign a_ext = {{(PW - CW){a_rdata[CW-1]}}, a_rdata};
    assign x_ext = {{(PW - XW){tap_x[XW-1]}}, tap_x};
    assign prod  = a_ext * x_ext;

    // Round half up, then form the residue one bit wider than needed
    assign rsum = {acc[ACC_W-1], acc} + HALF;
    assign pq   = rsum >>> CFRAC;
    assign xr   = {{(RW - XW){xn[XW-1]}}, xn};
    assign pr   = {pq[ACC_W], pq};
    assign r    = xr - pr;

    always_comb begin
        clip      = 1'b0;
        res_wdata = '0;
        if (state == S_WRITE) begin
            if (r > RMAX) begin
                clip      = 1'b1;
                res_wdata = RMAX[XW-1:0];
            end else if (r < RMIN) begin
                clip      = 1'b1;
                res_wdata = RMIN[XW-1:0];
            end else begin
                res_wdata = r[XW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_ISSUE;
            S_ISSUE: if (last_tap) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_WRITE;
            S_WRITE: state_nxt = last_n ? S_DONE : S_ISSUE;
            S_DONE:  state_nxt = start ? S_ISSUE : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n      <= '0;
            k      <= '0;
            kd     <= '0;
            kd_vld <= 1'b0;
            acc    <= '0;
            xn     <= '0;
            sat    <= 1'b0;
        end else begin
            kd_vld <= (state == S_ISSUE);
            kd     <= k;
            if (accept) begin
                n   <= '0;
                k   <= '0;
                sat <= 1'b0;
            end else if (state == S_ISSUE) begin
                k <= k + KCW'(1);
            end else if (state == S_WRITE) begin
                k <= '0;
                n <= n + ADDR_W'(1);
                if (clip) sat <= 1'b1;
            end
            if (state == S_ISSUE && k == '0) begin
                acc <= '0;
            end else if (kd_vld && kd != '0) begin
                acc <= acc + {{(ACC_W - PW){prod[PW-1]}}, prod};
            end
            if (kd_vld && kd == '0) xn <= x_rdata;
        end
    end

    // Shadow fills during the frame; live history only changes at frame end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < ORDER; j++) begin
                hist[j]   <= '0;
                shadow[j] <= '0;
            end
        end else begin
            if (state == S_WRITE) begin
                for (int j = 0; j < ORDER; j++) begin
                    if (n == ADDR_W'(FRAME_LEN - 1 - j)) shadow[j] <= xn;
                end
            end
            if (state == S_DONE) begin
                for (int j = 0; j < ORDER; j++) hist[j] <= shadow[j];
            end
            if (accept && clear_history) begin
                for (int j = 0; j < ORDER; j++) hist[j] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ifilter_lattice_free_p.sv
// Directed bench for ifilter_lattice_free_p: an ORDER=10 instance for
// frame timing and an ORDER=2 instance for arithmetic, history and protocol.
module tb_ifilter_lattice_free_p;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic               start10 = 1'b0, clr10 = 1'b0;
    logic               ready10, done10, sat10;
    logic [3:0]         a_raddr10;
    logic signed [31:0] a_rdata10;
    logic [7:0]         x_raddr10;
    logic signed [15:0] x_rdata10;
    logic [7:0]         res_waddr10;
    logic               res_wen10;
    logic signed [15:0] res_wdata10;

    logic               start2 = 1'b0, clr2 = 1'b0;
    logic               ready2, done2, sat2;
    logic [0:0]         a_raddr2;
    logic signed [31:0] a_rdata2;
    logic [7:0]         x_raddr2;
    logic signed [15:0] x_rdata2;
    logic [7:0]         res_waddr2;
    logic               res_wen2;
    logic signed [15:0] res_wdata2;

    ifilter_lattice_free_p u_d10 (
        .clk(clk), .reset(reset),
        .start(start10), .clear_history(clr10),
        .ready(ready10), .done(done10), .sat(sat10),
        .a_raddr(a_raddr10), .a_rdata(a_rdata10),
        .x_raddr(x_raddr10), .x_rdata(x_rdata10),
        .res_waddr(res_waddr10), .res_wen(res_wen10),
        .res_wdata(res_wdata10)
    );

    ifilter_lattice_free_p #(.ORDER(2)) u_d2 (
        .clk(clk), .reset(reset),
        .start(start2), .clear_history(clr2),
        .ready(ready2), .done(done2), .sat(sat2),
        .a_raddr(a_raddr2), .a_rdata(a_rdata2),
        .x_raddr(x_raddr2), .x_rdata(x_rdata2),
        .res_waddr(res_waddr2), .res_wen(res_wen2),
        .res_wdata(res_wdata2)
    );

    logic signed [15:0] xmem [256];
    logic signed [31:0] amem [16];
    logic signed [15:0] res10 [256];
    logic signed [15:0] res2 [256];

    always @(posedge clk) begin
        x_rdata10 <= xmem[x_raddr10];
        a_rdata10 <= amem[a_raddr10];
        x_rdata2  <= xmem[x_raddr2];
        a_rdata2  <= amem[a_raddr2];
    end

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int wcnt [2], dcnt [2], firstw [2], donec [2], ord_err [2];
    int lastw [2];

    always @(negedge clk) begin
        if (res_wen10) begin
            if (wcnt[0] > 0 && int'(res_waddr10) <= lastw[0])
                ord_err[0]++;
            if (wcnt[0] == 0) firstw[0] = cyc;
            lastw[0] = int'(res_waddr10);
            res10[res_waddr10] = res_wdata10;
            wcnt[0]++;
        end
        if (done10) begin
            dcnt[0]++;
            donec[0] = cyc;
        end
        if (res_wen2) begin
            if (wcnt[1] > 0 && int'(res_waddr2) <= lastw[1])
                ord_err[1]++;
            if (wcnt[1] == 0) firstw[1] = cyc;
            lastw[1] = int'(res_waddr2);
            res2[res_waddr2] = res_wdata2;
            wcnt[1]++;
        end
        if (done2) begin
            dcnt[1]++;
            donec[1] = cyc;
        end
    end

    int n_chk = 0;
    int n_err = 0;
    int t0 = 0;

    task automatic check(input string tag, input longint got,
                         input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_counts(input int sel);
        wcnt[sel]    = 0;
        dcnt[sel]    = 0;
        firstw[sel]  = -1;
        donec[sel]   = -1;
        ord_err[sel] = 0;
        lastw[sel]   = -1;
        for (int i = 0; i < 256; i++) begin
            if (sel == 0) res10[i] = 16'sh5a5a;
            else          res2[i]  = 16'sh5a5a;
        end
    endtask

    // sel 0 = ORDER 10 instance, 1 = ORDER 2; poke >= 0 pulses start mid-frame
    task automatic run_frame(input int sel, input logic clr,
                             input int poke);
        clear_counts(sel);
        if (sel == 0) begin start10 = 1'b1; clr10 = clr; end
        else          begin start2  = 1'b1; clr2  = clr; end
        @(negedge clk);
        t0 = cyc;
        start10 = 1'b0; clr10 = 1'b0;
        start2  = 1'b0; clr2  = 1'b0;
        check("ready_drop", (sel == 0) ? ready10 : ready2, 0);
        check("sat_clear", (sel == 0) ? sat10 : sat2, 0);
        for (int i = 0; i < 4000 && dcnt[sel] == 0; i++) begin
            if (sel == 1) start2 = (i == poke);
            @(negedge clk);
        end
        start2 = 1'b0;
        repeat (3) @(negedge clk);
        check("done_once", dcnt[sel], 1);
        check("wr_count", wcnt[sel], 256);
        check("wr_order", ord_err[sel], 0);
    endtask

    int bad;
    int found;

    initial begin
        for (int i = 0; i < 256; i++) xmem[i] = '0;
        for (int i = 0; i < 16; i++) amem[i] = '0;
        clear_counts(0);
        clear_counts(1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", ready10, 1);
        check("rst_done", done10, 0);
        check("rst_sat", sat10, 0);
        check("rst_wen", res_wen10, 0);
        check("rst_xaddr", x_raddr10, 0);
        check("rst_aaddr", a_raddr10, 0);
        check("rst_wdata", res_wdata10, 0);
        check("rst_ready2", ready2, 1);
        check("rst_waddr2", res_waddr2, 0);

        // all coefficients zero: residue is the input itself
        for (int i = 0; i < 256; i++) xmem[i] = 16'(i - 128);
        run_frame(0, 1'b1, -1);
        check("t1_first_wr", firstw[0] - t0 + 1, 13);
        check("t1_done_lat", donec[0] - t0 + 1, 3329);
        bad = 0;
        for (int i = 0; i < 256; i++) if (res10[i] != xmem[i]) bad++;
        check("t1_res_all", bad, 0);
        check("t1_res0", res10[0], -128);
        check("t1_res255", res10[255], 127);
        check("t1_sat", sat10, 0);
        check("t1_ready", ready10, 1);

        // a1 = 1.0: first difference
        amem[0] = 32'sd16777216;
        amem[1] = '0;
        for (int i = 0; i < 256; i++) xmem[i] = 16'(i);
        run_frame(1, 1'b1, -1);
        check("t2_first_wr", firstw[1] - t0 + 1, 5);
        check("t2_done_lat", donec[1] - t0 + 1, 1281);
        check("t2_res0", res2[0], 0);
        check("t2_res1", res2[1], 1);
        check("t2_res255", res2[255], 1);
        bad = 0;
        for (int i = 1; i < 256; i++) if (res2[i] != 16'sd1) bad++;
        check("t2_res_all", bad, 0);
        check("t2_sat", sat2, 0);

        // saturation both ways
        for (int i = 0; i < 256; i++) xmem[i] = '0;
        xmem[0] = 16'sd32767;
        xmem[1] = -16'sd32768;
        run_frame(1, 1'b1, -1);
        check("t3_res0", res2[0], 32767);
        check("t3_res1_lo", res2[1], -32768);
        check("t3_res2_hi", res2[2], 32767);
        check("t3_res3", res2[3], 0);
        check("t3_sat", sat2, 1);
        repeat (5) @(negedge clk);
        check("t3_sat_hold", sat2, 1);

        // a1 = 0.5: round half up
        amem[0] = 32'sd8388608;
        for (int i = 0; i < 256; i++) xmem[i] = '0;
        xmem[0] = 16'sd3;
        run_frame(1, 1'b1, -1);
        check("t4_res0", res2[0], 3);
        check("t4_res1_pos", res2[1], -2);
        xmem[0] = -16'sd3;
        run_frame(1, 1'b1, -1);
        check("t4_res1_neg", res2[1], 1);
        check("t4_sat", sat2, 0);

        // history across frames
        amem[0] = 32'sd16777216;
        for (int i = 0; i < 256; i++) xmem[i] = '0;
        xmem[255] = 16'sd100;
        run_frame(1, 1'b1, -1);
        xmem[0] = 16'sd100;
        run_frame(1, 1'b0, -1);
        check("t5_hist_res0", res2[0], 0);
        check("t5_hist_res1", res2[1], -100);
        run_frame(1, 1'b1, -1);
        check("t5_clr_res0", res2[0], 100);

        // start while busy is ignored
        run_frame(1, 1'b1, 100);
        repeat (20) @(negedge clk);
        check("t6_one_done", dcnt[1], 1);
        check("t6_idle", ready2, 1);

        // reset mid-frame aborts without done
        clear_counts(1);
        start2 = 1'b1;
        clr2 = 1'b0;
        @(negedge clk);
        start2 = 1'b0;
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge clk);
            if (res_wen2 && res_waddr2 == 8'd39) found = 1;
        end
        check("t7_reach", found, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t7_ready", ready2, 1);
        check("t7_wen", res_wen2, 0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("t7_wcnt", wcnt[1], 40);
        check("t7_no_done", dcnt[1], 0);

        // reset cleared history
        xmem[0] = 16'sd50;
        run_frame(1, 1'b0, -1);
        check("t8_zero_hist", res2[0], 50);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=%0d exp=0", cyc);
        $fatal(1, "timeout");
    end

endmodule
